// File: rtl/conv_sched_pkg.sv
// Shared definitions for the convolution row scheduler and the sram
// controllers that decode its state outputs.
package conv_sched_pkg;

  localparam int MAST_W = 3;
  localparam int SLAV_W = 2;

  // FSLD keeps code 7 so existing sram controllers decode it unchanged.
  typedef enum logic [MAST_W-1:0] {
    M_IDLE  = 3'd0,
    M_LEFT  = 3'd1,
    M_BASE  = 3'd2,
    M_RIGHT = 3'd3,
    M_DONE  = 3'd4,
    M_FSLD  = 3'd7
  } mast_state_t;

  typedef enum logic [SLAV_W-1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1
  } slav_state_t;

  typedef enum logic [1:0] {
    TILE_NONE  = 2'd0,
    TILE_LEFT  = 2'd1,
    TILE_BASE  = 2'd2,
    TILE_RIGHT = 2'd3
  } tile_kind_t;

  // Which tile (if any) a master state is working on.
  function automatic tile_kind_t tile_kind_of(mast_state_t s);
    case (s)
      M_LEFT:  return TILE_LEFT;
      M_BASE:  return TILE_BASE;
      M_RIGHT: return TILE_RIGHT;
      default: return TILE_NONE;
    endcase
  endfunction

endpackage

// File: rtl/conv_row_sched_if.sv
// Control/status bundle between the row engine sequencer and the scheduler.
//
// Handshake semantics: there is no valid/ready pair. start is a single-cycle
// request honoured only while the scheduler is idle; fsld_end and krow_done are
// single-cycle completion strobes qualified by the scheduler state (ignored when
// the scheduler is not waiting for them); abort is a level that wins over all
// other inputs on the cycle it is sampled.
interface conv_row_sched_if #(
  parameter int TILE_W = 8,
  parameter int ROW_W  = 9,
  parameter int KR_W   = 2
);
  logic              start;
  logic              abort;
  logic [TILE_W-1:0] cfg_num_base;
  logic [ROW_W-1:0]  cfg_num_rows;
  logic              fsld_end;
  logic              krow_done;

  logic [2:0]        mast_state;
  logic [1:0]        slav_state;
  logic [KR_W-1:0]   krow_idx;
  logic [TILE_W-1:0] tile_idx;
  logic [ROW_W-1:0]  row_idx;
  logic              tile_done;
  logic              busy;
  logic              done;

  // Sequencer side: issues commands, observes progress.
  modport master (
    output start, abort, cfg_num_base, cfg_num_rows, fsld_end, krow_done,
    input  mast_state, slav_state, krow_idx, tile_idx, row_idx,
           tile_done, busy, done
  );

  // Scheduler side.
  modport slave (
    input  start, abort, cfg_num_base, cfg_num_rows, fsld_end, krow_done,
    output mast_state, slav_state, krow_idx, tile_idx, row_idx,
           tile_done, busy, done
  );
endinterface

// File: rtl/krow_counter.sv
// Kernel-row counter: counts 0..KROWS-1, wraps to 0 after the last row.
// clear has priority over inc.
module krow_counter #(
  parameter int KROWS = 3,
  parameter int KR_W  = $clog2(KROWS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            inc,
  output logic [KR_W-1:0] idx,
  output logic            last
);

  logic [KR_W-1:0] idx_q;

  assign idx  = idx_q;
  assign last = (idx_q == KR_W'(KROWS - 1));

  // Count kernel rows, wrapping after the bottom row.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      idx_q <= '0;
    end else if (inc) begin
      idx_q <= last ? '0 : idx_q + KR_W'(1);
    end
  end

endmodule

// File: rtl/conv_row_sched.sv
// Convolution row scheduler: first load, then per output row a LEFT tile,
// cfg_num_base BASE tiles and a RIGHT tile, each of KROWS kernel rows.
module conv_row_sched
  import conv_sched_pkg::*;
#(
  parameter int KROWS  = 3,
  parameter int TILE_W = 8,
  parameter int ROW_W  = 9,
  parameter int KR_W   = $clog2(KROWS)
) (
  input logic              clk,
  input logic              reset,
  conv_row_sched_if.slave  bus
);

  mast_state_t       mast_q, mast_d;
  slav_state_t       slav_q, slav_d;
  logic [TILE_W-1:0] tile_q, tile_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [TILE_W-1:0] base_q, base_d;
  logic [ROW_W-1:0]  rows_q, rows_d;
  logic              tile_done_q, tile_done_d;

  logic [KR_W-1:0]   krow_idx;
  logic              krow_last;
  logic              krow_inc;
  logic              krow_clear;
  logic              tile_end;

  // krow_done only counts while a tile is running.
  assign krow_inc   = (slav_q == S_RUN) && bus.krow_done;
  assign tile_end   = krow_inc && krow_last;
  // Entering LEFT from the first load starts the kernel rows afresh.
  assign krow_clear = bus.abort || ((mast_q == M_FSLD) && bus.fsld_end);

  krow_counter #(
    .KROWS (KROWS),
    .KR_W  (KR_W)
  ) u_krow (
    .clk   (clk),
    .reset (reset),
    .clear (krow_clear),
    .inc   (krow_inc),
    .idx   (krow_idx),
    .last  (krow_last)
  );

  // Master next state, tile/row counters and config latch.
  always_comb begin
    mast_d = mast_q;
    tile_d = tile_q;
    row_d  = row_q;
    base_d = base_q;
    rows_d = rows_q;
    if (bus.abort) begin
      mast_d = M_IDLE;
      tile_d = '0;
      row_d  = '0;
    end else begin
      case (mast_q)
        M_IDLE: begin
          if (bus.start) begin
            base_d = bus.cfg_num_base;
            rows_d = bus.cfg_num_rows;
            tile_d = '0;
            row_d  = '0;
            mast_d = (bus.cfg_num_rows != '0) ? M_FSLD : M_DONE;
          end
        end
        M_FSLD: begin
          if (bus.fsld_end) mast_d = M_LEFT;
        end
        M_LEFT: begin
          if (tile_end) mast_d = (base_q != '0) ? M_BASE : M_RIGHT;
        end
        M_BASE: begin
          if (tile_end) begin
            if (tile_q != base_q - TILE_W'(1)) begin
              tile_d = tile_q + TILE_W'(1);
            end else begin
              tile_d = '0;
              mast_d = M_RIGHT;
            end
          end
        end
        M_RIGHT: begin
          if (tile_end) begin
            if (row_q != rows_q - ROW_W'(1)) begin
              row_d  = row_q + ROW_W'(1);
              tile_d = '0;
              mast_d = M_LEFT;
            end else begin
              mast_d = M_DONE;
            end
          end
        end
        M_DONE: begin
          mast_d = M_IDLE;
          tile_d = '0;
          row_d  = '0;
        end
        default: begin
          mast_d = M_IDLE;
          tile_d = '0;
          row_d  = '0;
        end
      endcase
    end
  end

  // Slave follows the master: running whenever a tile is being processed.
  always_comb begin
    slav_d      = (tile_kind_of(mast_d) != TILE_NONE) ? S_RUN : S_IDLE;
    tile_done_d = tile_end && !bus.abort;
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      mast_q      <= M_IDLE;
      slav_q      <= S_IDLE;
      tile_q      <= '0;
      row_q       <= '0;
      base_q      <= '0;
      rows_q      <= '0;
      tile_done_q <= 1'b0;
    end else begin
      mast_q      <= mast_d;
      slav_q      <= slav_d;
      tile_q      <= tile_d;
      row_q       <= row_d;
      base_q      <= base_d;
      rows_q      <= rows_d;
      tile_done_q <= tile_done_d;
    end
  end

  assign bus.mast_state = mast_q;
  assign bus.slav_state = slav_q;
  assign bus.krow_idx   = krow_idx;
  assign bus.tile_idx   = tile_q;
  assign bus.row_idx    = row_q;
  assign bus.tile_done  = tile_done_q;
  assign bus.busy       = (mast_q != M_IDLE);
  assign bus.done       = (mast_q == M_DONE);

endmodule
